// File: rtl/fir_decim_pkg.sv
// Shared fixed-point constants and FSM encoding for the FM receive audio chain.
// Samples and coefficients are signed integers scaled by QUANT_VAL.
package fir_decim_pkg;

  localparam int BITS        = 10;
  localparam int QUANT_VAL   = 1 << BITS;
  localparam int MAX_TAPS    = 64;
  localparam int ADUIO_DECIM = 8;
  localparam int DEQ_W       = 128;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  // Divide by QUANT_VAL rounding toward zero: negatives get a bias before the arithmetic shift.
  function automatic logic signed [DEQ_W-1:0] dequantize_p(input logic signed [DEQ_W-1:0] p);
    logic signed [DEQ_W-1:0] bias;
    bias = p[DEQ_W-1] ? DEQ_W'(QUANT_VAL - 1) : '0;
    return (p + bias) >>> BITS;
  endfunction

endpackage

// File: rtl/fir_decim_mac.sv
// Registered multiply, truncating dequantize and wrapping accumulate.
// busy_o is high while a registered product is still waiting to be accumulated.
module fir_mac
  import fir_decim_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] coef_i,
  input  logic signed [DATA_W-1:0] samp_i,
  output logic signed [DATA_W-1:0] acc_o,
  output logic                     busy_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_q;
  logic                     pend_q;
  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] acc_d;
  logic signed [DATA_W-1:0] deq;

  assign deq   = DATA_W'(dequantize_p(DEQ_W'(prod_q)));
  assign acc_d = acc_q + deq;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
      pend_q <= 1'b0;
      acc_q  <= '0;
    end else if (clr_i) begin
      pend_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      pend_q <= en_i;
      if (en_i) begin
        prod_q <= PROD_W'(coef_i) * PROD_W'(samp_i);
      end
      if (pend_q) begin
        acc_q <= acc_d;
      end
    end
  end

  assign acc_o  = acc_q;
  assign busy_o = pend_q;

endmodule

// File: rtl/fir_decim.sv
// Streaming decimating FIR: collects DECIM samples, then runs one time-multiplexed MAC pass.
//   state | meaning
//   LOAD  | accept input samples into the delay line
//   MAC   | one tap per cycle through fir_mac, TAPS cycles
//   OUT   | wait for the last product to drain, then hold out_data until out_ready
module fir_decim
  import fir_decim_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int DECIM  = ADUIO_DECIM,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [TAPS*DATA_W-1:0]   coeffs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int LOAD_W = 8;

  if (TAPS < 1 || TAPS > MAX_TAPS) begin : g_bad_taps
    $error("fir_decim: TAPS out of range");
  end
  if (DECIM < 1 || DECIM > 255) begin : g_bad_decim
    $error("fir_decim: DECIM out of range");
  end

  fir_state_t                state_q, state_d;
  logic [LOAD_W-1:0]         load_cnt_q, load_cnt_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];

  logic                      accept;
  logic                      out_fire;
  logic                      mac_clr;
  logic                      mac_en;
  logic                      mac_busy;
  logic signed [DATA_W-1:0]  mac_acc;
  logic signed [DATA_W-1:0]  coef_sel;
  logic signed [DATA_W-1:0]  samp_sel;

  assign in_ready  = (state_q == LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == OUT) && !mac_busy;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = mac_acc;

  assign coef_sel = coeffs[int'(tap_q)*DATA_W +: DATA_W];
  assign samp_sel = x_q[tap_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      tap_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      tap_q      <= tap_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
    end else if (accept) begin
      x_q[0] <= in_data;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    tap_d      = tap_q;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (load_cnt_q == LOAD_W'(DECIM - 1)) begin
            load_cnt_d = '0;
            tap_d      = '0;
            mac_clr    = 1'b1;
            state_d    = MAC;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_q == TAP_W'(TAPS - 1)) begin
          tap_d   = '0;
          state_d = OUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      OUT: begin
        if (out_fire) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  fir_mac #(.DATA_W(DATA_W)) u_mac (
    .clk_i   (clock),
    .rst_n_i (reset_n),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .coef_i  (coef_sel),
    .samp_i  (samp_sel),
    .acc_o   (mac_acc),
    .busy_o  (mac_busy)
  );

endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
- Streaming decimating FIR filter for the FM receive chain. It sits directly downstream of the FM demodulator and produces audio-rate samples at 1/DECIM of the demodulator output rate.
- Uses a single multiplier in a time-multiplexed multiply-accumulate (MAC) loop.
- Samples and coefficients are fixed-point integers in the shared quantization format: QUANT_VAL = 1<<BITS, BITS = 10.
- Valid/ready handshake on both input and output.

Parameters:
- TAPS, 32: number of filter taps; legal range 1..MAX_TAPS.
- DECIM, 8: decimation factor (ADUIO_DECIM); legal range 1..255.
- DATA_W, 32: sample, coefficient and accumulator width, signed.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_W  signed quantized input sample.
- coeffs  in  TAPS*DATA_W  signed quantized coefficients; c[k] = coeffs[k*DATA_W +: DATA_W]; static while reset_n is high.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  signed quantized filtered sample.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all outputs are 0 except in_ready, which is 1. Shift register x[0..TAPS-1] = 0, accumulator = 0, counters = 0, state = LOAD.
- Reset asserted mid-operation discards any partial sum and any pending output.
- States:
  - LOAD: in_ready = 1. When in_valid && in_ready, shift: x[k] <= x[k-1] for k ≥ 1, x[0] <= in_data; load_cnt++. When the accepted sample makes load_cnt == DECIM: clear load_cnt, clear acc, tap = 0, go to MAC.
  - MAC: in_ready = 0. Each cycle, acc <= acc + DEQ(c[tap]*x[tap]) and tap++. After tap == TAPS-1 is accumulated, go to OUT. Duration is exactly TAPS cycles.
  - OUT: out_valid = 1 and out_data = acc, both held stable until out_ready. On out_valid && out_ready, go to LOAD. in_ready is 1 again in the following cycle.
- Arithmetic:
  - Product is formed at 2*DATA_W bits.
  - DEQ(p) = p / QUANT_VAL, truncating toward zero (not an arithmetic shift): DEQ(-1) = 0, DEQ(-1025) = -1.
  - The truncated product is cast to DATA_W bits.
  - acc is DATA_W bits and wraps two's-complement on overflow; no saturation.
- Result: out_data = Σ_{k=0}^{TAPS-1} DEQ(c[k]*x[k]), using the x contents at the moment of the DECIM-th accept.
- Latency: from the DECIM-th accepted sample to out_valid is TAPS+1 cycles.
- Throughput: a full group of DECIM samples takes at least DECIM + TAPS + 1 cycles.
- Boundary conditions:
  - DECIM = 1: every accepted sample triggers a MAC pass.
  - TAPS = 1: a single MAC cycle.
  - Input stall (in_valid low): LOAD holds with no state change.
  - Output backpressure (out_ready low): OUT holds with out_data stable.
  - in_valid while not in LOAD: ignored, no accept.
- Coefficient changes while not in reset: undefined result.

Decomposition:
- GLOBALS package: BITS, QUANT_VAL, MAX_TAPS, ADUIO_DECIM, and a DEQUANTIZE_P function operating on 2*DATA_W-bit products.
- Also in GLOBALS: a typedef enum fir_state_t {LOAD, MAC, OUT}.
- Sub-module fir_mac: registered multiply, truncating dequantize, and accumulate, with clr/en inputs. Kept separate so the audio low-pass and de-emphasis stages can reuse it.

Test Plan:
- Impulse: TAPS=4, DECIM=1, c = {1024, 2048, -1024, 512}; inputs 1024, 0, 0, 0 → outputs 1024, 2048, -1024, 512. Each out_valid arrives 5 cycles after its accept.
- DC decimation: TAPS=32, DECIM=8, all c = 32 (1/32); constant input 4096 → first output 1024 (only 8 taps filled), then 2048, 3072, then 4096 steady. One output per 8 inputs.
- Truncation: TAPS=1, DECIM=1, c = 1; inputs -1 and -1025 → outputs 0 and -1. Verifies truncation toward zero, not floor.
- Backpressure: hold out_ready=0 for 20 cycles in OUT → out_valid and out_data stable and in_ready = 0 throughout. Release → one transfer, and in_ready = 1 in the next cycle.
- Reset mid-MAC: assert reset_n=0 on MAC cycle 10 → all outputs 0 and in_ready=1 during reset. After release, the impulse test reproduces outputs identical to a fresh start, with no stale taps.
- Random stress: random in_valid/out_ready with a reference-model scoreboard → every output matches the model; out_valid is never dropped without a handshake; no accepts occur outside LOAD.
